// File: rtl/result_queue_fifo_pkg.sv
// Shared definitions for the detection-result queue.
// Holds the result-word field layout, the default queue depth and the
// write/read transfer structs used by the computation side and by the queue.
package result_queue_fifo_pkg;

  localparam int unsigned RQ_DATA_W        = 32;
  localparam int unsigned RQ_DEFAULT_DEPTH = 64;

  // Result word layout: {scale, y, x}
  localparam int unsigned RQ_X_LSB     = 0;
  localparam int unsigned RQ_X_W       = 12;
  localparam int unsigned RQ_Y_LSB     = 12;
  localparam int unsigned RQ_Y_W       = 12;
  localparam int unsigned RQ_SCALE_LSB = 24;
  localparam int unsigned RQ_SCALE_W   = 8;

  typedef struct packed {
    logic [RQ_SCALE_W-1:0] scale;
    logic [RQ_Y_W-1:0]     y;
    logic [RQ_X_W-1:0]     x;
  } rq_result_t;

  // Writer -> queue
  typedef struct packed {
    logic       valid;
    rq_result_t data;
  } rq_wr_req_t;

  // Queue -> writer
  typedef struct packed {
    logic ready;
    logic afull;
  } rq_wr_rsp_t;

  // Queue -> reader
  typedef struct packed {
    logic       valid;
    rq_result_t data;
  } rq_rd_rsp_t;

  function automatic rq_result_t rq_pack(input logic [RQ_X_W-1:0]     x,
                                         input logic [RQ_Y_W-1:0]     y,
                                         input logic [RQ_SCALE_W-1:0] scale);
    rq_result_t r;
    r.x     = x;
    r.y     = y;
    r.scale = scale;
    return r;
  endfunction

endpackage

// File: rtl/result_queue_ram.sv
// Simple dual-port storage for the result queue: one write port and one
// registered read port, inferable as block RAM.
// Ports:
//   clk      - clock
//   wr_en    - write strobe; wr_data stored at wr_addr
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - load the read register from rd_addr
//   rd_rst   - synchronous clear of the read register (not of the array)
//   rd_addr  - read address
//   rd_data  - registered read data; holds when rd_en is low
module result_queue_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic                     rd_rst,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/result_queue_fifo.sv
// Result queue: buffers detection results from the result-store stage and
// presents them first-word-fall-through to the host/DMA reader.
// The registered read port of the RAM is the one-entry output stage, so a
// word pushed into an empty queue is written on the push edge and appears
// on rd_data after the following edge.
// Ports:
//   clk, reset (sync, active-high), clear (sync flush, storage untouched)
//   wr_valid/wr_data/wr_ready - write handshake; wr_afull near-full warning
//   rd_valid/rd_data/rd_ready - read handshake, head entry
//   count/empty/full          - occupancy, including the output stage
// Optional: define RESULT_QUEUE_STATS_EN to add stat_pushes, stat_stalls
// and stat_hwm (saturating, cleared by reset or clear).
module result_queue_fifo
  import result_queue_fifo_pkg::*;
#(
  parameter int unsigned DATA_W       = RQ_DATA_W,
  parameter int unsigned DEPTH        = RQ_DEFAULT_DEPTH,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  output logic                   wr_afull,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
`ifdef RESULT_QUEUE_STATS_EN
  ,
  output logic [31:0]            stat_pushes,
  output logic [31:0]            stat_stalls,
  output logic [$clog2(DEPTH):0] stat_hwm
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull  = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntAfull = CntW'(DEPTH - AFULL_MARGIN);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] mem_count;
  logic            rd_valid_q, rd_valid_d;
  logic            flush, push, pop, load;

  // clear and reset act alike on everything except the storage array
  assign flush = reset | clear;

  always_comb begin
    full     = (count_q == CntFull);
    empty    = (count_q == '0);
    wr_ready = !full;
    wr_afull = (count_q >= CntAfull);
    rd_valid = rd_valid_q;
    count    = count_q;

    push = wr_valid & wr_ready;
    pop  = rd_valid_q & rd_ready;

    // Entries sitting in the array, excluding the one in the output stage
    mem_count = count_q - CntW'(rd_valid_q);
    // Refill the output stage when it is empty or being popped this cycle
    load = (mem_count != '0) && (!rd_valid_q || rd_ready);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = rd_valid_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (load) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_valid_d = 1'b1;
    end else if (pop) begin
      rd_valid_d = 1'b0;
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  result_queue_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push & !flush),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (load),
    .rd_rst  (flush),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

`ifdef RESULT_QUEUE_STATS_EN
  logic [31:0]     pushes_q, stalls_q;
  logic [CntW-1:0] hwm_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      pushes_q <= '0;
      stalls_q <= '0;
      hwm_q    <= '0;
    end else begin
      if (push && (pushes_q != '1)) begin
        pushes_q <= pushes_q + 32'd1;
      end
      if (wr_valid && !wr_ready && (stalls_q != '1)) begin
        stalls_q <= stalls_q + 32'd1;
      end
      if (count_q > hwm_q) begin
        hwm_q <= count_q;
      end
    end
  end

  assign stat_pushes = pushes_q;
  assign stat_stalls = stalls_q;
  assign stat_hwm    = hwm_q;
`endif

endmodule

// File: tb/tb_result_queue_fifo.sv
module tb_result_queue_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset, clear, wr_valid, rd_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready, wr_afull, rd_valid, empty, full;
  logic [DATA_W-1:0] rd_data;
  logic [6:0]        count;
`ifdef RESULT_QUEUE_STATS_EN
  logic [31:0]       stat_pushes, stat_stalls;
  logic [6:0]        stat_hwm;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  result_queue_fifo #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .wr_afull (wr_afull),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .count    (count),
    .empty    (empty),
    .full     (full)
`ifdef RESULT_QUEUE_STATS_EN
    ,
    .stat_pushes (stat_pushes),
    .stat_stalls (stat_stalls),
    .stat_hwm    (stat_hwm)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic fill(input int n, input logic [DATA_W-1:0] base);
    rd_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + DATA_W'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    fill(3, 32'h77);
    do_reset();
    vectors++; if (count !== 7'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
    vectors++; if (wr_ready !== 1'b1 || wr_afull !== 1'b0) begin miscompares++; $display("FAIL reset_wr ready=%b afull=%b exp 1/0", wr_ready, wr_afull); end
    vectors++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd valid=%b data=%h exp 0/0", rd_valid, rd_data); end
  endtask

  task automatic test_single();
    do_reset();
    wr_valid = 1'b1; wr_data = 32'hA5A5_0001;
    tick();
    wr_valid = 1'b0;
    vectors++; if (rd_valid !== 1'b0 || count !== 7'd1) begin miscompares++; $display("FAIL single_edge1 rd_valid=%b count=%0d exp 0/1", rd_valid, count); end
    tick();
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL single_edge2 rd_valid=%b data=%h exp 1/a5a50001", rd_valid, rd_data); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    vectors++; if (empty !== 1'b1 || count !== 7'd0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop empty=%b count=%0d rd_valid=%b exp 1/0/0", empty, count, rd_valid); end
  endtask

  task automatic test_empty_pop();
    do_reset();
    rd_ready = 1'b1;
    tick(); tick();
    rd_ready = 1'b0;
    vectors++; if (count !== 7'd0 || rd_valid !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL empty_pop count=%0d rd_valid=%b empty=%b exp 0/0/1", count, rd_valid, empty); end
  endtask

  task automatic test_fill_drain();
    logic        acc;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1; wr_data = 32'(i);
      vectors++; if (wr_ready !== 1'b1 || wr_afull !== (i >= 60)) begin miscompares++; $display("FAIL fill_%0d wr_ready=%b afull=%b exp 1/%b", i, wr_ready, wr_afull, (i >= 60)); end
      tick();
    end
    wr_data = 32'h100;
    vectors++; if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 7'd64 || wr_afull !== 1'b1) begin miscompares++; $display("FAIL fill_full full=%b ready=%b count=%0d afull=%b exp 1/0/64/1", full, wr_ready, count, wr_afull); end
    tick(); tick();
    vectors++; if (count !== 7'd64) begin miscompares++; $display("FAIL fill_held count=%0d exp 64", count); end
    rd_ready = 1'b1;
    for (int k = 0; k < 65; k++) begin
      exp_d = (k < 64) ? 32'(k) : 32'h100;
      vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin miscompares++; $display("FAIL drain_%0d rd_valid=%b data=%h exp 1/%h", k, rd_valid, rd_data, exp_d); end
      acc = wr_valid & wr_ready;
      tick();
      if (acc) wr_valid = 1'b0;
    end
    rd_ready = 1'b0;
    vectors++; if (count !== 7'd0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL drain_end count=%0d rd_valid=%b exp 0/0", count, rd_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    fill(32, 32'h200);
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      wr_data = 32'h200 + 32'(32 + j);
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 32'h200 + 32'(j)) begin miscompares++; $display("FAIL stream_%0d rd_valid=%b data=%h exp 1/%h", j, rd_valid, rd_data, 32'h200 + 32'(j)); end
      tick();
      vectors++; if (count !== 7'd32) begin miscompares++; $display("FAIL stream_cnt_%0d count=%0d exp 32", j, count); end
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_d;
    do_reset();
    fill(64, 32'h300);
    wr_valid = 1'b1; wr_data = 32'h3FF; rd_ready = 1'b1;
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL fullpop_ready got %b exp 0", wr_ready); end
    tick();
    rd_ready = 1'b0;
    vectors++; if (count !== 7'd63 || rd_data !== 32'h301 || wr_ready !== 1'b1) begin miscompares++; $display("FAIL fullpop_63 count=%0d data=%h ready=%b exp 63/301/1", count, rd_data, wr_ready); end
    tick();
    wr_valid = 1'b0;
    vectors++; if (count !== 7'd64 || full !== 1'b1) begin miscompares++; $display("FAIL fullpop_64 count=%0d full=%b exp 64/1", count, full); end
    rd_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      exp_d = (k < 63) ? 32'h301 + 32'(k) : 32'h3FF;
      vectors++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin miscompares++; $display("FAIL fullpop_drain_%0d rd_valid=%b data=%h exp 1/%h", k, rd_valid, rd_data, exp_d); end
      tick();
    end
    rd_ready = 1'b0;
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fullpop_empty got %b exp 1", empty); end
  endtask

  task automatic test_clear();
    do_reset();
    fill(10, 32'h400);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 32'hDEAD; rd_ready = 1'b1;
    tick();
    clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    vectors++; if (count !== 7'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin miscompares++; $display("FAIL clear count=%0d empty=%b rd_valid=%b data=%h exp 0/1/0/0", count, empty, rd_valid, rd_data); end
    tick();
    vectors++; if (rd_valid !== 1'b0 || count !== 7'd0) begin miscompares++; $display("FAIL clear_stale rd_valid=%b count=%0d exp 0/0", rd_valid, count); end
    wr_valid = 1'b1; wr_data = 32'h500;
    tick();
    wr_valid = 1'b0;
    tick();
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 32'h500 || count !== 7'd1) begin miscompares++; $display("FAIL clear_next rd_valid=%b data=%h count=%0d exp 1/500/1", rd_valid, rd_data, count); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    fill(5, 32'h600);
    reset = 1'b1; wr_valid = 1'b1; wr_data = 32'hBEEF; rd_ready = 1'b1;
    tick();
    reset = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    tick();
    vectors++; if (count !== 7'd0 || rd_valid !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL midreset count=%0d rd_valid=%b empty=%b exp 0/0/1", count, rd_valid, empty); end
  endtask

`ifdef RESULT_QUEUE_STATS_EN
  task automatic test_stats();
    do_reset();
    fill(64, 32'h700);
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    fill(6, 32'h800);
    vectors++; if (stat_pushes !== 32'd70) begin miscompares++; $display("FAIL stat_pushes got %0d exp 70", stat_pushes); end
    vectors++; if (stat_stalls !== 32'd5) begin miscompares++; $display("FAIL stat_stalls got %0d exp 5", stat_stalls); end
    vectors++; if (stat_hwm !== 7'd64) begin miscompares++; $display("FAIL stat_hwm got %0d exp 64", stat_hwm); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++; if (stat_pushes !== 32'd0 || stat_stalls !== 32'd0 || stat_hwm !== 7'd0) begin miscompares++; $display("FAIL stat_clear pushes=%0d stalls=%0d hwm=%0d exp 0/0/0", stat_pushes, stat_stalls, stat_hwm); end
  endtask
`endif

  initial begin
    reset = 1'b1; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    tick();
    test_reset();
    test_single();
    test_empty_pop();
    test_fill_drain();
    test_stream();
    test_full_pop();
    test_clear();
    test_reset_midop();
`ifdef RESULT_QUEUE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
